reg_write_scheduler: RTL and testbench
======================================

# reg_write_scheduler

Sequences configuration-register writes into the SPI-programmed register bank (7 × 8-bit: color1–4, sprite_x, sprite_y, misc). Two requesters share the single write port:
- A: the SPI command/data decoder.
- B: the on-chip sprite/colour animator.

Requests are round-robin arbitrated, buffered in a small FIFO and committed only while `vblank_i` is high, so visible registers never change mid-frame.

## Interface
Parameters:
- `NUM_REGISTERS`, 7: number of writable registers; addresses ≥ this are illegal.
- `LEN_REGISTER`, 8: register data width.
- `ADDR_W`, 3: address width (≥ $clog2(NUM_REGISTERS)).
- `FIFO_DEPTH`, 4: pending-write entries, power of two, ≥ 2.

Ports:
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: reset. One clock; reset is asynchronous and active-low.
- `enable`  in  1: block enable; low freezes acceptance and draining, FIFO contents retained.
- `vblank_i`  in  1: synchronous to `clk_i`; high during vertical blanking.
- `a_valid_i` / `a_addr_i` / `a_data_i` / `a_ready_o`  in/in/in/out  1/ADDR_W/LEN_REGISTER/1: requester A handshake.
- `b_valid_i` / `b_addr_i` / `b_data_i` / `b_ready_o`  in/in/in/out  1/ADDR_W/LEN_REGISTER/1: requester B handshake.
- `wr_en_o`  out  1: one-cycle write strobe to the register bank.
- `wr_addr_o`  out  ADDR_W: write address.
- `wr_data_o`  out  LEN_REGISTER: write data.
- `level_o`  out  $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `addr_err_o`  out  1: one-cycle pulse when an illegal address is accepted.

## Operation
- Handshake:
  - A transfer occurs at a rising edge where valid and ready are both high.
  - A requester holds valid, addr and data stable until the transfer.
- Ready:
  - `x_ready_o` is combinational and equals `enable && rst_ni && !full && grant==x`.
  - At most one transfer per cycle.
- Grant (combinational):
  - Only one requester valid: that requester gets the grant.
  - Both valid: the requester not recorded in `last_grant` gets the grant.
  - Neither valid: no grant.
  - `last_grant` updates only on a transfer. Reset value = B, so A wins the first tie.
- Push:
  - A transfer with `addr < NUM_REGISTERS` writes {addr, data} at the FIFO tail.
  - A transfer with an illegal address completes (ready was high) but is discarded. `addr_err_o` pulses the following cycle and the level is unchanged.
- Full / empty:
  - full = (`level_o == FIFO_DEPTH`). Full is evaluated before any same-cycle pop, so a full FIFO refuses pushes even while draining.
  - empty = (`level_o == 0`).
- State machine, states IDLE, WAIT, DRAIN:
  - IDLE: FIFO empty. Any push → WAIT.
  - WAIT: `enable && vblank_i` → DRAIN. Otherwise stay.
  - DRAIN, with `enable && vblank_i && !empty`:
    - Pop the FIFO head.
    - Register the head as `wr_addr_o`/`wr_data_o` with `wr_en_o`=1 for exactly the next cycle.
  - DRAIN exits:
    - Level becomes 0 after a pop with no same-cycle push → IDLE.
    - `vblank_i` low or `enable` low → WAIT, with no pop that edge.
- Simultaneous push and pop in DRAIN: the level is unchanged and order is preserved (strict FIFO, no coalescing of same-address writes).
- Write ports: `wr_addr_o`/`wr_data_o` hold their last value when `wr_en_o` is low.
- Reset mid-operation (async): FIFO is emptied, state → IDLE, in-flight write dropped, `wr_en_o` deasserts immediately.

## Timing
- Reset values:
  - `wr_en_o`=0, `wr_addr_o`=0, `wr_data_o`=0, `level_o`=0, `addr_err_o`=0.
  - `a_ready_o`=`b_ready_o`=0 while `rst_ni` low.
  - state=IDLE, `last_grant`=B.
- Minimum latency, with `vblank_i` high throughout:
  - push at edge N (IDLE→WAIT);
  - WAIT→DRAIN at N+1;
  - pop at N+2;
  - `wr_en_o` high in the cycle after N+2.
- Drain throughput: one write per cycle while `vblank_i` stays high.
- `level_o` is registered and updates on the push/pop edge.
- `addr_err_o` is registered, one cycle after the offending transfer.

## Test plan
- Single write: A pushes {addr 4, data 0x3C} with `vblank_i`=0 → `level_o`=1, no `wr_en_o`. Raise `vblank_i` → exactly one `wr_en_o` pulse with addr 4 / data 0x3C, 3 edges after the push edge counted from vblank high. `level_o`=0, state IDLE.
- Round-robin: A and B both valid continuously, `vblank_i`=0, depth 4 → grants A,B,A,B. Then both readies go low (full). During drain, writes emerge in the same A,B,A,B order.
- Full/refill: fill to 4 entries, hold B valid, then vblank → cycle 1: pop, B refused. Cycle 2 onward: B accepted while popping, level holds at 3.
- Vblank cut: 4 entries queued, `vblank_i` high for exactly 2 drain cycles → 2 writes, `level_o`=2, state WAIT. Next vblank → the remaining 2 writes in order.
- Illegal address: A pushes addr 7 → `a_ready_o` high, `addr_err_o` pulses once, `level_o` unchanged, no write ever issued.
- Reset mid-drain: assert `rst_ni` low while `wr_en_o`=1 with 2 entries pending → all outputs 0 immediately. After release, no stale write appears on a subsequent vblank.

Source files
------------

// File: rtl/reg_write_scheduler.sv
// reg_write_scheduler
// Arbitrates configuration-register writes from two requesters (A: SPI decoder,
// B: sprite/colour animator) round-robin into a small FIFO, then commits them to
// the register bank only while vblank_i is high so visible registers never change
// mid-frame.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   enable                   low freezes acceptance and draining (contents kept)
//   vblank_i                 high during vertical blanking (sync to clk_i)
//   a_valid_i/addr/data      requester A request; a_ready_o combinational accept
//   b_valid_i/addr/data      requester B request; b_ready_o combinational accept
//   wr_en_o/addr/data        registered one-cycle write strobe to the register bank
//   level_o                  registered FIFO occupancy
//   addr_err_o               registered pulse after an illegal-address transfer
module reg_write_scheduler #(
  parameter int unsigned NUM_REGISTERS = 7,
  parameter int unsigned LEN_REGISTER  = 8,
  parameter int unsigned ADDR_W        = 3,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          enable,
  input  logic                          vblank_i,
  input  logic                          a_valid_i,
  input  logic [ADDR_W-1:0]             a_addr_i,
  input  logic [LEN_REGISTER-1:0]       a_data_i,
  output logic                          a_ready_o,
  input  logic                          b_valid_i,
  input  logic [ADDR_W-1:0]             b_addr_i,
  input  logic [LEN_REGISTER-1:0]       b_data_i,
  output logic                          b_ready_o,
  output logic                          wr_en_o,
  output logic [ADDR_W-1:0]             wr_addr_o,
  output logic [LEN_REGISTER-1:0]       wr_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          addr_err_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CMP_W = ADDR_W + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  typedef struct packed {
    logic [ADDR_W-1:0]       addr;
    logic [LEN_REGISTER-1:0] data;
  } wr_entry_t;

  logic [1:0]       state_q, state_d;
  logic             last_grant_b_q;  // 1: B won the last transfer
  wr_entry_t        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;

  logic      grant_a, grant_b, full, empty;
  logic      xfer_a, xfer_b, xfer, legal, push, pop, drain_ok;
  wr_entry_t req, head;

  // Round-robin grant, ready and transfer decode
  always_comb begin
    grant_a   = a_valid_i && (!b_valid_i || last_grant_b_q);
    grant_b   = b_valid_i && (!a_valid_i || !last_grant_b_q);
    full      = (level_o == LVL_W'(FIFO_DEPTH));
    empty     = (level_o == '0);
    a_ready_o = enable && rst_ni && !full && grant_a;
    b_ready_o = enable && rst_ni && !full && grant_b;
    xfer_a    = a_valid_i && a_ready_o;
    xfer_b    = b_valid_i && b_ready_o;
    xfer      = xfer_a || xfer_b;
    req.addr  = xfer_b ? b_addr_i : a_addr_i;
    req.data  = xfer_b ? b_data_i : a_data_i;
    // Extra bit keeps the compare correct when NUM_REGISTERS == 2**ADDR_W
    legal     = ({1'b0, req.addr} < CMP_W'(NUM_REGISTERS));
    push      = xfer && legal;
    drain_ok  = enable && vblank_i;
    pop       = (state_q == DRAIN) && drain_ok && !empty;
    head      = mem_q[rd_ptr_q];
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (push) state_d = WAIT;
      WAIT:    if (drain_ok) state_d = DRAIN;
      DRAIN: begin
        if (!drain_ok) begin
          state_d = WAIT;
        end else if (empty || ((level_o == LVL_W'(1)) && !push)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointers, occupancy, arbitration history and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      last_grant_b_q <= 1'b1;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_o        <= '0;
      wr_en_o        <= 1'b0;
      wr_addr_o      <= '0;
      wr_data_o      <= '0;
      addr_err_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_en_o    <= pop;
      addr_err_o <= xfer && !legal;
      if (xfer) last_grant_b_q <= xfer_b;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
        wr_addr_o <= head.addr;
        wr_data_o <= head.data;
      end
      case ({push, pop})
        2'b10:   level_o <= level_o + LVL_W'(1);
        2'b01:   level_o <= level_o - LVL_W'(1);
        default: level_o <= level_o;
      endcase
    end
  end

  // FIFO storage; validity is tracked by the pointers so no reset needed
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= req;
  end

endmodule

// File: tb/tb_reg_write_scheduler.sv
module tb_reg_write_scheduler;

  localparam int unsigned NREG = 7;

  logic       clk_i = 1'b0;
  logic       rst_ni, enable, vblank_i;
  logic       a_valid_i, b_valid_i, a_ready_o, b_ready_o;
  logic [2:0] a_addr_i, b_addr_i, wr_addr_o;
  logic [7:0] a_data_i, b_data_i, wr_data_o;
  logic       wr_en_o, addr_err_o;
  logic [2:0] level_o;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   ka, kb;

  reg_write_scheduler #(
    .NUM_REGISTERS(7), .LEN_REGISTER(8), .ADDR_W(3), .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable(enable), .vblank_i(vblank_i),
    .a_valid_i(a_valid_i), .a_addr_i(a_addr_i), .a_data_i(a_data_i), .a_ready_o(a_ready_o),
    .b_valid_i(b_valid_i), .b_addr_i(b_addr_i), .b_data_i(b_data_i), .b_ready_o(b_ready_o),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .level_o(level_o), .addr_err_o(addr_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1ns later and score any write strobe
  task automatic tick();
    exp_t e;
    @(posedge clk_i);
    #1;
    if (wr_en_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr", 32'(wr_en_o), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr_o), 32'(e.addr));
        check("wr_data", 32'(wr_data_o), 32'(e.data));
      end
    end
  endtask

  // Check readies against expectation, record expected legal pushes, then clock
  task automatic cyc(input logic ea, input logic eb);
    #1;
    check("a_ready", 32'(a_ready_o), 32'(ea));
    check("b_ready", 32'(b_ready_o), 32'(eb));
    if (a_valid_i && ea && (32'(a_addr_i) < NREG)) exp_q.push_back('{a_addr_i, a_data_i});
    if (b_valid_i && eb && (32'(b_addr_i) < NREG)) exp_q.push_back('{b_addr_i, b_data_i});
    tick();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; a_valid_i = 1'b0; b_valid_i = 1'b0; vblank_i = 1'b0; enable = 1'b1;
    tick();
    tick();
    rst_ni = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    rst_ni = 1'b1; enable = 1'b1; vblank_i = 1'b0;
    a_valid_i = 1'b1; a_addr_i = 3'd4; a_data_i = 8'h3C;
    b_valid_i = 1'b1; b_addr_i = 3'd5; b_data_i = 8'h55;
    #1 rst_ni = 1'b0;
    #2;
    check("rst_wr_en", 32'(wr_en_o), 32'd0);
    check("rst_wr_addr", 32'(wr_addr_o), 32'd0);
    check("rst_wr_data", 32'(wr_data_o), 32'd0);
    check("rst_level", 32'(level_o), 32'd0);
    check("rst_addr_err", 32'(addr_err_o), 32'd0);
    check("rst_a_ready", 32'(a_ready_o), 32'd0);
    check("rst_b_ready", 32'(b_ready_o), 32'd0);
    a_valid_i = 1'b0; b_valid_i = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;

    // Single write, latency counted from vblank rising
    a_valid_i = 1'b1; a_addr_i = 3'd4; a_data_i = 8'h3C;
    cyc(1'b1, 1'b0);
    a_valid_i = 1'b0;
    check("t1_level_q", 32'(level_o), 32'd1);
    check("t1_no_wr", 32'(wr_en_o), 32'd0);
    tick();
    tick();
    check("t1_hold_level", 32'(level_o), 32'd1);
    check("t1_hold_no_wr", 32'(wr_en_o), 32'd0);
    vblank_i = 1'b1;
    tick();
    check("t1_wait_no_wr", 32'(wr_en_o), 32'd0);
    tick();
    check("t1_wr_en", 32'(wr_en_o), 32'd1);
    check("t1_level_0", 32'(level_o), 32'd0);
    tick();
    check("t1_wr_single", 32'(wr_en_o), 32'd0);
    check("t1_addr_hold", 32'(wr_addr_o), 32'd4);
    check("t1_data_hold", 32'(wr_data_o), 32'h3C);
    tick();
    check("t1_idle_no_wr", 32'(wr_en_o), 32'd0);
    vblank_i = 1'b0;

    // Round-robin from reset: A,B,A,B then full
    do_reset();
    ka = 0; kb = 0;
    a_valid_i = 1'b1; b_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_addr_i = 3'(ka); a_data_i = 8'hA0 + 8'(ka);
      b_addr_i = 3'd5;   b_data_i = 8'hB0 + 8'(kb);
      if (i == 4) begin
        cyc(1'b0, 1'b0);
      end else begin
        cyc(i % 2 == 0, i % 2 == 1);
        if (i % 2 == 0) ka++; else kb++;
      end
    end
    check("t2_level_full", 32'(level_o), 32'd4);
    a_valid_i = 1'b0; b_valid_i = 1'b0; vblank_i = 1'b1;
    tick();
    check("t2_wait_no_wr", 32'(wr_en_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_drain_wr", 32'(wr_en_o), 32'd1);
      check("t2_drain_level", 32'(level_o), 32'(3 - i));
    end
    tick();
    check("t2_drain_done", 32'(wr_en_o), 32'd0);
    vblank_i = 1'b0;

    // Full then refill while draining
    a_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_addr_i = 3'(i); a_data_i = 8'hC0 + 8'(i);
      cyc(1'b1, 1'b0);
    end
    a_valid_i = 1'b0; b_valid_i = 1'b1; b_addr_i = 3'd6; b_data_i = 8'h60; vblank_i = 1'b1;
    cyc(1'b0, 1'b0);
    check("t3_e0_no_wr", 32'(wr_en_o), 32'd0);
    check("t3_e0_level", 32'(level_o), 32'd4);
    cyc(1'b0, 1'b0);
    check("t3_e1_wr", 32'(wr_en_o), 32'd1);
    check("t3_e1_level", 32'(level_o), 32'd3);
    cyc(1'b0, 1'b1);
    check("t3_e2_wr", 32'(wr_en_o), 32'd1);
    check("t3_e2_level", 32'(level_o), 32'd3);
    b_data_i = 8'h61;
    cyc(1'b0, 1'b1);
    check("t3_e3_wr", 32'(wr_en_o), 32'd1);
    check("t3_e3_level", 32'(level_o), 32'd3);
    b_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_tail_wr", 32'(wr_en_o), 32'd1);
      check("t3_tail_level", 32'(level_o), 32'(2 - i));
    end
    tick();
    check("t3_done", 32'(wr_en_o), 32'd0);
    vblank_i = 1'b0;

    // Vblank cut after two drains, enable freeze, then resume
    a_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_addr_i = 3'(6 - i); a_data_i = 8'hD0 + 8'(i);
      cyc(1'b1, 1'b0);
    end
    a_valid_i = 1'b0; vblank_i = 1'b1;
    tick();
    check("t4_e0_no_wr", 32'(wr_en_o), 32'd0);
    tick();
    check("t4_e1_wr", 32'(wr_en_o), 32'd1);
    tick();
    check("t4_e2_wr", 32'(wr_en_o), 32'd1);
    vblank_i = 1'b0;
    tick();
    check("t4_cut_no_wr", 32'(wr_en_o), 32'd0);
    check("t4_cut_level", 32'(level_o), 32'd2);
    tick();
    tick();
    check("t4_wait_level", 32'(level_o), 32'd2);
    enable = 1'b0; vblank_i = 1'b1;
    a_valid_i = 1'b1; a_addr_i = 3'd0; a_data_i = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0);
      check("t4_frozen_no_wr", 32'(wr_en_o), 32'd0);
    end
    check("t4_frozen_level", 32'(level_o), 32'd2);
    a_valid_i = 1'b0; enable = 1'b1;
    tick();
    check("t4_resume_wait", 32'(wr_en_o), 32'd0);
    tick();
    check("t4_resume_wr1", 32'(wr_en_o), 32'd1);
    check("t4_resume_lvl1", 32'(level_o), 32'd1);
    tick();
    check("t4_resume_wr2", 32'(wr_en_o), 32'd1);
    check("t4_resume_lvl0", 32'(level_o), 32'd0);
    tick();
    check("t4_resume_done", 32'(wr_en_o), 32'd0);
    check("t4_sb_empty", 32'(exp_q.size()), 32'd0);
    vblank_i = 1'b0;

    // Illegal address accepted and discarded
    a_valid_i = 1'b1; a_addr_i = 3'd7; a_data_i = 8'h77;
    cyc(1'b1, 1'b0);
    a_valid_i = 1'b0;
    check("t5_addr_err", 32'(addr_err_o), 32'd1);
    check("t5_level", 32'(level_o), 32'd0);
    tick();
    check("t5_addr_err_pulse", 32'(addr_err_o), 32'd0);
    vblank_i = 1'b1;
    repeat (4) tick();
    check("t5_no_wr", 32'(wr_en_o), 32'd0);
    check("t5_level_end", 32'(level_o), 32'd0);
    vblank_i = 1'b0;

    // Async reset while a write is on the bus with two entries pending
    a_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_addr_i = 3'(i + 1); a_data_i = 8'hF0 + 8'(i);
      cyc(1'b1, 1'b0);
    end
    a_valid_i = 1'b0; vblank_i = 1'b1;
    tick();
    tick();
    tick();
    check("t6_pre_wr", 32'(wr_en_o), 32'd1);
    check("t6_pre_level", 32'(level_o), 32'd2);
    a_valid_i = 1'b1; a_addr_i = 3'd2; a_data_i = 8'h22;
    rst_ni = 1'b0;
    #1;
    check("t6_rst_wr_en", 32'(wr_en_o), 32'd0);
    check("t6_rst_level", 32'(level_o), 32'd0);
    check("t6_rst_wr_addr", 32'(wr_addr_o), 32'd0);
    check("t6_rst_wr_data", 32'(wr_data_o), 32'd0);
    check("t6_rst_a_ready", 32'(a_ready_o), 32'd0);
    exp_q.delete();
    a_valid_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    repeat (5) tick();
    check("t6_post_no_wr", 32'(wr_en_o), 32'd0);
    check("t6_post_level", 32'(level_o), 32'd0);
    vblank_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
